// File: rtl/state_duration_timer_if.sv
// Control/status bundle between the train controller and its dwell timer.
// The controller side is master; the timer side is slave.
interface state_duration_timer_if #(
  parameter int STATE_W = 4,
  parameter int T_W     = 19
);
  logic [STATE_W-1:0] present_state;
  logic               pause;
  logic               cfg_we;
  logic [STATE_W-1:0] cfg_addr;
  logic [T_W-1:0]     cfg_data;
  logic [T_W-1:0]     t;
  logic [T_W-1:0]     remaining;
  logic               busy;
  logic               expired;

  modport master (
    output present_state, pause, cfg_we, cfg_addr, cfg_data,
    input  t, remaining, busy, expired
  );

  modport slave (
    input  present_state, pause, cfg_we, cfg_addr, cfg_data,
    output t, remaining, busy, expired
  );
endinterface

// File: rtl/state_duration_timer.sv
// Per-state dwell timer: reloads a programmable ms duration on every state change,
// counts it down in real milliseconds and pulses expired once per completed dwell.
module state_duration_timer #(
  parameter int CLK_FREQ = 50000000,
  parameter int STATE_W  = 4,
  parameter int T_W      = 19,
  parameter int DEF_T3   = 2000,
  parameter int DEF_T4   = 1000,
  parameter int DEF_T5   = 2000
) (
  input  logic                  clk,
  input  logic                  rst,
  state_duration_timer_if.slave bus
);
  localparam int P     = CLK_FREQ / 1000;
  localparam int P_W   = $clog2(P);
  localparam int DEPTH = 2 ** STATE_W;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t             state_reg, state_next;
  logic [STATE_W-1:0] prev_state_reg, prev_state_next;
  logic               first_reg, first_next;
  logic [P_W-1:0]     pcnt_reg, pcnt_next;
  logic [T_W-1:0]     remaining_reg, remaining_next;
  logic               expired_reg, expired_next;
  logic [T_W-1:0]     t_reg;
  logic [T_W-1:0]     tbl [DEPTH];
  logic [T_W-1:0]     rd_data;
  logic               load;

  // Table entries are individual registers because every entry must reset to a default.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
    localparam logic [T_W-1:0] DEF = (gi == 3) ? T_W'(DEF_T3) :
                                     (gi == 4) ? T_W'(DEF_T4) :
                                     (gi == 5) ? T_W'(DEF_T5) : '0;
    logic [T_W-1:0] entry_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        entry_reg <= DEF;
      end else if (bus.cfg_we && bus.cfg_addr == STATE_W'(gi)) begin
        entry_reg <= bus.cfg_data;
      end
    end

    assign tbl[gi] = entry_reg;
  end

  // A write landing on the entry being read is forwarded so load and t see it immediately.
  assign rd_data = (bus.cfg_we && bus.cfg_addr == bus.present_state) ? bus.cfg_data
                                                                     : tbl[bus.present_state];
  assign load    = first_reg || (bus.present_state != prev_state_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      prev_state_reg <= '0;
      first_reg      <= 1'b1;
      pcnt_reg       <= '0;
      remaining_reg  <= '0;
      expired_reg    <= 1'b0;
      t_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      prev_state_reg <= prev_state_next;
      first_reg      <= first_next;
      pcnt_reg       <= pcnt_next;
      remaining_reg  <= remaining_next;
      expired_reg    <= expired_next;
      t_reg          <= rd_data;
    end
  end

  always_comb begin
    state_next      = state_reg;
    prev_state_next = prev_state_reg;
    first_next      = first_reg;
    pcnt_next       = pcnt_reg;
    remaining_next  = remaining_reg;
    expired_next    = 1'b0;

    if (load) begin
      prev_state_next = bus.present_state;
      first_next      = 1'b0;
      pcnt_next       = '0;
      remaining_next  = rd_data;
      state_next      = (rd_data != '0) ? RUN : IDLE;
    end else begin
      case (state_reg)
        RUN, HOLD: begin
          if (bus.pause) begin
            state_next = HOLD;
          end else begin
            // Leaving HOLD counts on the same edge, so each held cycle costs exactly one cycle.
            state_next = RUN;
            if (pcnt_reg == P_W'(P - 1)) begin
              pcnt_next      = '0;
              remaining_next = remaining_reg - T_W'(1);
              if (remaining_reg == T_W'(1)) begin
                state_next   = IDLE;
                expired_next = 1'b1;
              end
            end else begin
              pcnt_next = pcnt_reg + P_W'(1);
            end
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign bus.t         = t_reg;
  assign bus.remaining = remaining_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.expired   = expired_reg;
endmodule
